// File: rtl/oqpsk_bit_feeder_pkg.sv
// Shared types and constants for the OQPSK bit feeder.
// The wrap address is the last ROM address the modulator visits before latching a new bit.
package oqpsk_bit_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam int PS_SMPLS_DEF = 50;

  function automatic logic [5:0] wrap_addr(input int ps_smpls);
    return 6'(ps_smpls - 1);
  endfunction

  localparam logic [5:0] WRAP_ADDR = wrap_addr(PS_SMPLS_DEF);

endpackage

// File: rtl/oqpsk_byte_fifo.sv
// Synchronous byte FIFO; registered state, rdata shows the head entry combinationally.
// A push while full is dropped unless a pop happens in the same cycle.
module oqpsk_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [W-1:0]           wdata_i,
  input  logic                   pop_i,
  output logic [W-1:0]           rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != DEPTH_C) || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q];
  assign full_o  = (cnt_q == DEPTH_C);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/oqpsk_bit_feeder.sv
// Buffers bytes and serializes them MSB-first to the OQPSK modulator, advancing one bit per ROM wrap, then zero-pads.
// Bits change one clk after the consume event; byte_ready drops only when the FIFO is full.
module oqpsk_bit_feeder
  import oqpsk_bit_feeder_pkg::*;
#(
  parameter int DIV        = 8,
  parameter int REQ_HI     = 2,
  parameter int SETTLE     = 3,
  parameter int PS_SMPLS   = PS_SMPLS_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int FLUSH_BITS = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic [5:0] add_i,
  input  logic [5:0] add_q,
  output logic       req_sample,
  output logic       bit_out,
  output logic       en_out,
  output logic       busy,
  output logic       underrun
);

  localparam int PW = $clog2(DIV);
  localparam int FW = $clog2(FLUSH_BITS + 1);
  localparam logic [5:0] WRAP = wrap_addr(PS_SMPLS);

  state_e                        state_q, state_d;
  logic [PW-1:0]                 phase_q, phase_d;
  logic [7:0]                    sh_q, sh_d;
  logic [2:0]                    cnt_q, cnt_d;
  logic [FW-1:0]                 flush_q, flush_d;
  logic                          bit_q, bit_d;
  logic                          en_q, en_d;
  logic                          req_q, req_d;
  logic                          urun_q, urun_d;
  logic                          pend_q, pend_d;
  logic                          cev;
  logic                          fifo_pop;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [7:0]                    fifo_dat;
  logic [$clog2(FIFO_DEPTH):0]   fifo_cnt;

  oqpsk_byte_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (byte_valid && byte_ready),
    .wdata_i (byte_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_dat),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // Flags and occupancy must never disagree.
  always_comb begin
    assert (fifo_empty == (fifo_cnt == '0));
  end

  assign cev = (state_q != IDLE) && (phase_q == PW'(SETTLE)) && ((add_i == WRAP) || (add_q == WRAP));

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    flush_d  = flush_q;
    bit_d    = bit_q;
    en_d     = en_q;
    urun_d   = urun_q;
    pend_d   = pend_q;
    fifo_pop = 1'b0;
    phase_d  = (state_q == IDLE || phase_q == PW'(DIV - 1)) ? '0 : phase_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          sh_d     = fifo_dat;
          bit_d    = fifo_dat[7];
          cnt_d    = '0;
          pend_d   = 1'b0;
          en_d     = 1'b1;
          phase_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (cev) begin
          // pend_q: byte reloaded out of FLUSH, a zero is still on the line.
          if (pend_q) begin
            pend_d = 1'b0;
            bit_d  = sh_q[7];
          end else if (cnt_q != 3'd7) begin
            sh_d  = {sh_q[6:0], 1'b0};
            bit_d = sh_q[6];
            cnt_d = cnt_q + 3'd1;
          end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            sh_d     = fifo_dat;
            bit_d    = fifo_dat[7];
            cnt_d    = '0;
          end else begin
            bit_d   = 1'b0;
            flush_d = FW'(FLUSH_BITS);
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          sh_d     = fifo_dat;
          cnt_d    = '0;
          pend_d   = 1'b1;
          urun_d   = 1'b1;
          state_d  = RUN;
        end else if (cev) begin
          if (flush_q == FW'(1)) begin
            en_d    = 1'b0;
            phase_d = '0;
            state_d = IDLE;
          end else begin
            flush_d = flush_q - FW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    req_d = (state_d != IDLE) && (phase_d < PW'(REQ_HI));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      phase_q <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      flush_q <= '0;
      bit_q   <= 1'b0;
      en_q    <= 1'b0;
      req_q   <= 1'b0;
      urun_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      bit_q   <= bit_d;
      en_q    <= en_d;
      req_q   <= req_d;
      urun_q  <= urun_d;
      pend_q  <= pend_d;
    end
  end

  assign byte_ready = !fifo_full;
  assign req_sample = req_q;
  assign bit_out    = bit_q;
  assign en_out     = en_q;
  assign busy       = (state_q != IDLE);
  assign underrun   = urun_q;

endmodule

// File: tb/tb_oqpsk_bit_feeder.sv
// Directed bench for oqpsk_bit_feeder with a behavioural modulator address model.
// The model records the bit on the line in every period where an address reaches the wrap value.
module tb_oqpsk_bit_feeder;

  localparam int DIV    = 8;
  localparam int REQ_HI = 2;
  localparam int PS     = 50;
  localparam int BIT_CLKS = (PS / 2) * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       byte_valid = 1'b0;
  logic       byte_ready;
  logic [5:0] add_i;
  logic [5:0] add_q;
  logic       req_sample;
  logic       bit_out;
  logic       en_out;
  logic       busy;
  logic       underrun;

  int errors = 0;
  int checks = 0;

  logic       model_en = 1'b1;
  logic       model_rst = 1'b0;
  logic [5:0] mi = 6'd0;
  logic [5:0] mq = 6'd25;
  logic [5:0] fi = 6'd0;
  logic [5:0] fq = 6'd0;
  logic       req_prev = 1'b0;
  logic       cons_mem [0:255];
  int         ncons = 0;
  int         base = 0;
  logic       exp_q [$];

  assign add_i = model_en ? mi : fi;
  assign add_q = model_en ? mq : fq;

  always #5 clk = ~clk;

  oqpsk_bit_feeder dut (
    .clk        (clk),
    .reset      (reset),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .add_i      (add_i),
    .add_q      (add_q),
    .req_sample (req_sample),
    .bit_out    (bit_out),
    .en_out     (en_out),
    .busy       (busy),
    .underrun   (underrun)
  );

  // Modulator: both ROM addresses step after each req_sample rise.
  always @(posedge clk) begin
    #1;
    if (model_rst) begin
      mi = 6'd0;
      mq = 6'd25;
    end else if (model_en && req_sample && !req_prev) begin
      mi = (mi == 6'd49) ? 6'd0 : mi + 6'd1;
      mq = (mq == 6'd49) ? 6'd0 : mq + 6'd1;
      if (en_out && (mi == 6'd49 || mq == 6'd49) && ncons < 256) begin
        cons_mem[ncons] = bit_out;
        ncons++;
      end
    end
    req_prev = req_sample;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_restart();
    model_en  = 1'b1;
    model_rst = 1'b1;
    step(1);
    model_rst = 1'b0;
    base = ncons;
    exp_q.delete();
  endtask

  task automatic add_byte(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) exp_q.push_back(d[i]);
  endtask

  task automatic add_zeros(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(1'b0);
  endtask

  task automatic push_byte(input logic [7:0] d, output logic acc);
    @(negedge clk);
    byte_data  = d;
    byte_valid = 1'b1;
    acc        = byte_ready;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic wait_cons(input int n, input string nm);
    int k = 0;
    while ((ncons - base) < n && k < (n + 2) * BIT_CLKS) begin
      @(negedge clk);
      k++;
    end
    if ((ncons - base) < n) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: consumed %0d bits, need %0d", nm, ncons - base, n);
    end
  endtask

  task automatic wait_req_rise(output logic ok);
    logic p = req_sample;
    ok = 1'b0;
    for (int k = 0; k < 4 * DIV && !ok; k++) begin
      @(negedge clk);
      if (req_sample && !p) ok = 1'b1;
      p = req_sample;
    end
  endtask

  task automatic test_reset();
    logic acc;
    step(2);
    checks++;
    if ({req_sample, bit_out, en_out, busy, underrun, byte_ready} !== 6'b000001) begin
      errors++;
      $display("FAIL reset_init: outputs=%b want 000001", {req_sample, bit_out, en_out, busy, underrun, byte_ready});
    end
    reset = 1'b1;
    model_en = 1'b0;
    fi = 6'd20;
    fq = 6'd20;
    push_byte(8'hC3, acc);
    push_byte(8'h3C, acc);
    step(5);
    checks++;
    if ({en_out, busy} !== 2'b11) begin
      errors++;
      $display("FAIL reset_prerun: en,busy=%b want 11", {en_out, busy});
    end
    reset = 1'b0;
    step(1);
    checks++;
    if ({req_sample, bit_out, en_out, busy, underrun, byte_ready} !== 6'b000001) begin
      errors++;
      $display("FAIL reset_midrun: outputs=%b want 000001", {req_sample, bit_out, en_out, busy, underrun, byte_ready});
    end
    reset = 1'b1;
    step(20);
    checks++;
    if ({en_out, busy, byte_ready} !== 3'b001) begin
      errors++;
      $display("FAIL reset_fifo_empty: en,busy,ready=%b want 001", {en_out, busy, byte_ready});
    end
  endtask

  task automatic test_single();
    logic acc;
    model_restart();
    add_byte(8'hA5);
    add_zeros(6);
    push_byte(8'hA5, acc);
    wait_cons(exp_q.size(), "single");
    step(3 * DIV);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (cons_mem[base + i] !== exp_q[i]) begin
        errors++;
        $display("FAIL single_bit%0d: got %b want %b", i, cons_mem[base + i], exp_q[i]);
      end
    end
    checks++;
    if ((ncons - base) != exp_q.size() || {en_out, busy} !== 2'b00) begin
      errors++;
      $display("FAIL single_end: bits=%0d en,busy=%b want %0d 00", ncons - base, {en_out, busy}, exp_q.size());
    end
  endtask

  task automatic push_burst(input logic [7:0] vals [$], output logic [7:0] acc);
    acc = '0;
    @(negedge clk);
    for (int i = 0; i < vals.size(); i++) begin
      byte_data  = vals[i];
      byte_valid = 1'b1;
      acc[i]     = byte_ready;
      @(negedge clk);
    end
    byte_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [$];
    logic [7:0] acc;
    model_restart();
    vals = '{8'hFF, 8'h00};
    add_byte(8'hFF);
    add_byte(8'h00);
    add_zeros(6);
    push_burst(vals, acc);
    checks++;
    if (acc[1:0] !== 2'b11) begin
      errors++;
      $display("FAIL b2b_accept: got %b want 11", acc[1:0]);
    end
    wait_cons(exp_q.size(), "b2b");
    step(3 * DIV);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (cons_mem[base + i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_bit%0d: got %b want %b", i, cons_mem[base + i], exp_q[i]);
      end
    end
    checks++;
    if ((ncons - base) != exp_q.size() || {en_out, underrun} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_end: bits=%0d en,underrun=%b want %0d 00", ncons - base, {en_out, underrun}, exp_q.size());
    end
  endtask

  task automatic test_fill();
    logic [7:0] vals [$];
    logic [7:0] acc;
    model_restart();
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    for (int i = 0; i < 5; i++) add_byte(vals[i]);
    add_zeros(6);
    push_burst(vals, acc);
    checks++;
    if (acc[5:0] !== 6'b011111) begin
      errors++;
      $display("FAIL fill_accept: got %b want 011111", acc[5:0]);
    end
    checks++;
    if (byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_ready: got %b want 0", byte_ready);
    end
    wait_cons(exp_q.size(), "fill");
    step(3 * DIV);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (cons_mem[base + i] !== exp_q[i]) begin
        errors++;
        $display("FAIL fill_bit%0d: got %b want %b", i, cons_mem[base + i], exp_q[i]);
      end
    end
    checks++;
    if ((ncons - base) != exp_q.size() || {en_out, byte_ready} !== 2'b01) begin
      errors++;
      $display("FAIL fill_end: bits=%0d en,ready=%b want %0d 01", ncons - base, {en_out, byte_ready}, exp_q.size());
    end
  endtask

  task automatic test_underrun();
    logic acc;
    model_restart();
    add_byte(8'h80);
    add_zeros(2);
    add_byte(8'h01);
    add_zeros(6);
    push_byte(8'h80, acc);
    wait_cons(9, "underrun_pre");
    step(DIV);
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL underrun_pre: got %b want 0", underrun);
    end
    push_byte(8'h01, acc);
    wait_cons(exp_q.size(), "underrun");
    step(3 * DIV);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (cons_mem[base + i] !== exp_q[i]) begin
        errors++;
        $display("FAIL underrun_bit%0d: got %b want %b", i, cons_mem[base + i], exp_q[i]);
      end
    end
    checks++;
    if ((ncons - base) != exp_q.size() || {underrun, en_out} !== 2'b10) begin
      errors++;
      $display("FAIL underrun_end: bits=%0d underrun,en=%b want %0d 10", ncons - base, {underrun, en_out}, exp_q.size());
    end
  endtask

  task automatic test_double_wrap();
    logic acc;
    logic ok;
    int   n;
    model_en = 1'b0;
    fi = 6'd0;
    fq = 6'd0;
    push_byte(8'hA5, acc);
    step(3);
    checks++;
    if ({en_out, bit_out} !== 2'b11) begin
      errors++;
      $display("FAIL dbl_start: en,bit=%b want 11", {en_out, bit_out});
    end
    wait_req_rise(ok);
    fi = 6'd49;
    fq = 6'd49;
    step(4);
    fi = 6'd0;
    fq = 6'd0;
    step(4);
    checks++;
    if (!ok || bit_out !== 1'b0) begin
      errors++;
      $display("FAIL dbl_both_wrap: rise=%b bit=%b want 1 0", ok, bit_out);
    end
    wait_req_rise(ok);
    fi = 6'd49;
    step(4);
    fi = 6'd0;
    step(4);
    checks++;
    if (!ok || bit_out !== 1'b1) begin
      errors++;
      $display("FAIL dbl_i_wrap: rise=%b bit=%b want 1 1", ok, bit_out);
    end
    wait_req_rise(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL req_rise: got no rise want rise");
    end
    for (int k = 0; k < 2 * DIV; k++) begin
      checks++;
      if (req_sample !== ((k % DIV) < REQ_HI)) begin
        errors++;
        $display("FAIL req_run_clk%0d: got %b want %b", k, req_sample, (k % DIV) < REQ_HI);
      end
      @(negedge clk);
    end
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    n = 0;
    for (int k = 0; k < 3 * DIV; k++) begin
      if (req_sample) n++;
      @(negedge clk);
    end
    checks++;
    if (n != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL req_idle: pulses=%0d busy=%b want 0 0", n, busy);
    end
    model_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fill();
    test_underrun();
    test_double_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
